// File: rtl/daq_frame_ctrl.sv
// daq_frame_ctrl: packs ADC samples into framed byte streams for a byte FIFO.
// Frame layout: HDR0, HDR1, SEQ (frame counter), then per sample a high byte
// {otr,3'b000,data[11:8]} and a low byte data[7:0], then a TAIL byte holding
// the XOR of all sample bytes in the frame.
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   cfg_arm_i              pulse: start capture (IDLE only), latches frame length
//   cfg_stop_i             pulse: stop after the current frame's TAIL
//   cfg_frame_len_i        samples per frame, 0 means 1024
//   sample_vld_i/_data_i/_otr_i   ADC sample input
//   fifo_full_i            FIFO back-pressure
//   fifo_wr_o, fifo_data_o byte write strobe and data
//   busy_o                 not IDLE
//   frame_cnt_o            completed frames (wraps)
//   ovf_cnt_o, ovf_flag_o  dropped-sample count (saturating) and sticky flag
module daq_frame_ctrl #(
  parameter logic [7:0] HDR0  = 8'hA5,
  parameter logic [7:0] HDR1  = 8'h5A,
  parameter int         OVF_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_arm_i,
  input  logic             cfg_stop_i,
  input  logic [9:0]       cfg_frame_len_i,
  input  logic             sample_vld_i,
  input  logic [11:0]      sample_data_i,
  input  logic             sample_otr_i,
  input  logic             fifo_full_i,
  output logic             fifo_wr_o,
  output logic [7:0]       fifo_data_o,
  output logic             busy_o,
  output logic [7:0]       frame_cnt_o,
  output logic [OVF_W-1:0] ovf_cnt_o,
  output logic             ovf_flag_o
);

  typedef enum logic [2:0] {IDLE, H0, H1, SEQ, WAIT, SHI, SLO, TAIL} state_t;

  state_t      state_q, state_d;
  logic        hold_vld;
  logic [12:0] hold_q;      // {otr, data}
  logic        stop_pend;
  logic [7:0]  csum;
  logic [10:0] smp_cnt;
  logic [10:0] len_q;       // 11 bits so a length of 1024 fits
  logic        emit, wr, slo_wr, take, drop, last, to_idle;

  assign emit    = (state_q == H0) || (state_q == H1) || (state_q == SEQ) ||
                   (state_q == SHI) || (state_q == SLO) || (state_q == TAIL);
  assign wr      = emit && !fifo_full_i;
  assign slo_wr  = (state_q == SLO) && wr;
  // The SLO write frees the hold register in the same cycle, so a sample
  // arriving then is taken rather than counted as an overflow.
  assign take    = sample_vld_i && (state_q != IDLE) && (!hold_vld || slo_wr);
  assign drop    = sample_vld_i && (state_q != IDLE) && hold_vld && !slo_wr;
  assign last    = (smp_cnt + 11'd1) == len_q;
  assign to_idle = (state_q != IDLE) && (state_d == IDLE);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: emit states advance only on a cycle that actually writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_arm_i) state_d = H0;
      H0:   if (wr) state_d = H1;
      H1:   if (wr) state_d = SEQ;
      SEQ:  if (wr) state_d = hold_vld ? SHI : WAIT;
      WAIT: if (hold_vld) state_d = SHI;
      SHI:  if (wr) state_d = SLO;
      SLO:  if (wr) state_d = last ? TAIL : WAIT;
      TAIL: if (wr) state_d = stop_pend ? IDLE : H0;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: purely from registered state and hold register.
  always_comb begin
    fifo_data_o = 8'h00;
    case (state_q)
      H0:   fifo_data_o = HDR0;
      H1:   fifo_data_o = HDR1;
      SEQ:  fifo_data_o = frame_cnt_o;
      SHI:  fifo_data_o = {hold_q[12], 3'b000, hold_q[11:8]};
      SLO:  fifo_data_o = hold_q[7:0];
      TAIL: fifo_data_o = csum;
      default: fifo_data_o = 8'h00;
    endcase
  end

  assign fifo_wr_o = wr;
  assign busy_o    = (state_q != IDLE);

  // Hold register; flushed on return to IDLE so a late sample can't leak
  // into the next armed capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (take) begin
      hold_vld <= 1'b1;
      hold_q   <= {sample_otr_i, sample_data_i};
    end else if (slo_wr || to_idle) begin
      hold_vld <= 1'b0;
    end
  end

  // Frame bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q       <= '0;
      smp_cnt     <= '0;
      csum        <= '0;
      frame_cnt_o <= '0;
      stop_pend   <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_arm_i)
        len_q <= (cfg_frame_len_i == 10'd0) ? 11'd1024 : {1'b0, cfg_frame_len_i};
      if (state_q == H0 && wr) begin
        smp_cnt <= '0;
        csum    <= '0;
      end else begin
        if (slo_wr) smp_cnt <= smp_cnt + 11'd1;
        if ((state_q == SHI || state_q == SLO) && wr) csum <= csum ^ fifo_data_o;
      end
      if (state_q == TAIL && wr) frame_cnt_o <= frame_cnt_o + 8'd1;
      if (to_idle)                               stop_pend <= 1'b0;
      else if (cfg_stop_i && state_q != IDLE)    stop_pend <= 1'b1;
    end
  end

  // Overflow accounting; arm clears it, frame_cnt_o survives arm.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt_o  <= '0;
      ovf_flag_o <= 1'b0;
    end else if (state_q == IDLE && cfg_arm_i) begin
      ovf_cnt_o  <= '0;
      ovf_flag_o <= 1'b0;
    end else if (drop) begin
      ovf_flag_o <= 1'b1;
      if (ovf_cnt_o != {OVF_W{1'b1}}) ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_daq_frame_ctrl.sv
module tb_daq_frame_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_arm_i = 1'b0, cfg_stop_i = 1'b0;
  logic [9:0]  cfg_frame_len_i = '0;
  logic        sample_vld_i = 1'b0, sample_otr_i = 1'b0;
  logic [11:0] sample_data_i = '0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_o, busy_o, ovf_flag_o;
  logic [7:0]  fifo_data_o, frame_cnt_o;
  logic [15:0] ovf_cnt_o;

  daq_frame_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_arm_i(cfg_arm_i), .cfg_stop_i(cfg_stop_i),
    .cfg_frame_len_i(cfg_frame_len_i), .sample_vld_i(sample_vld_i),
    .sample_data_i(sample_data_i), .sample_otr_i(sample_otr_i),
    .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o), .ovf_cnt_o(ovf_cnt_o),
    .ovf_flag_o(ovf_flag_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, time %0t required < 2ms", $time);
    $fatal(1);
  end

  typedef struct {
    logic [9:0]       len;
    int               n;
    logic [3:0][12:0] smp;   // {otr, data}
    logic [7:0]       tail;
  } vec_t;

  vec_t        vt [4];
  logic [7:0]  sb [$];
  logic [12:0] smp_buf [1024];
  logic [7:0]  exp_fcnt = 8'h00;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every FIFO write against the scoreboard.
  task automatic mon();
    logic [7:0] e;
    if (fifo_wr_o) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_write: got %0h expected no write at %0t", fifo_data_o, $time);
      end else begin
        e = sb.pop_front();
        chk("fifo_byte", fifo_data_o, e);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    mon();
    @(posedge clk_i);
    #1;
    cfg_arm_i = 1'b0; cfg_stop_i = 1'b0; sample_vld_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy_o) && k < 200) begin
      cyc();
      k++;
    end
    chk("drain_timeout_left", sb.size(), 0);
  endtask

  task automatic push_smp(input logic [12:0] s);
    sb.push_back({s[12], 3'b000, s[11:8]});
    sb.push_back(s[7:0]);
  endtask

  // Arm a frame with smp_buf[0..n-1], stop requested with the first sample.
  task automatic run_frame(input logic [9:0] len, input int n, input logic [7:0] tail);
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(exp_fcnt);
    for (int i = 0; i < n; i++) push_smp(smp_buf[i]);
    sb.push_back(tail);
    cfg_frame_len_i = len; cfg_arm_i = 1'b1;
    cyc();
    for (int i = 0; i < n; i++) begin
      sample_vld_i = 1'b1; sample_otr_i = smp_buf[i][12]; sample_data_i = smp_buf[i][11:0];
      if (i == 0) cfg_stop_i = 1'b1;
      cyc();
      repeat (3) cyc();
    end
    wait_idle();
    exp_fcnt = exp_fcnt + 8'd1;
    chk("frame_cnt", frame_cnt_o, exp_fcnt);
  endtask

  initial begin
    logic [7:0]  t;
    logic [12:0] s;
    // vectors: {len, sample count, samples, expected TAIL}
    foreach (vt[i]) vt[i].smp = '0;
    vt[0].len = 10'd2; vt[0].n = 2; vt[0].smp[0] = 13'h0123; vt[0].smp[1] = 13'h0ABC; vt[0].tail = 8'h94;
    vt[1].len = 10'd1; vt[1].n = 1; vt[1].smp[0] = 13'h17FF; vt[1].tail = 8'h78;
    vt[2].len = 10'd4; vt[2].n = 4; vt[2].smp[0] = 13'h0000; vt[2].smp[1] = 13'h0FFF;
    vt[2].smp[2] = 13'h0555; vt[2].smp[3] = 13'h00AA; vt[2].tail = 8'h0A;
    vt[3].len = 10'd3; vt[3].n = 3; vt[3].smp[0] = 13'h1800; vt[3].smp[1] = 13'h0001;
    vt[3].smp[2] = 13'h13C3; vt[3].tail = 8'hC9;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wr", fifo_wr_o, 0); chk("rst_data", fifo_data_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_fcnt", frame_cnt_o, 0); chk("rst_ovf", ovf_cnt_o, 0); chk("rst_flag", ovf_flag_o, 0);
    rst_i = 1'b0;
    cyc();

    // table-driven frames (first is A5 5A 00 01 23 0A BC 94)
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vt[v].n; i++) smp_buf[i] = vt[v].smp[i];
      run_frame(vt[v].len, vt[v].n, vt[v].tail);
      chk("busy_after_stop", busy_o, 0);
      chk("ovf_none", ovf_cnt_o, 0);
    end
    cyc();
    chk("no_restart_wr", fifo_wr_o, 0);

    // stall in H1 for 3 cycles
    s = 13'h0456;
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(exp_fcnt);
    push_smp(s); sb.push_back(8'h52);
    cfg_frame_len_i = 10'd1; cfg_arm_i = 1'b1;
    cyc();
    cyc();
    fifo_full_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      mon();
      chk("stall_wr", fifo_wr_o, 0);
      chk("stall_data", fifo_data_o, 8'h5A);
      @(posedge clk_i);
      #1;
    end
    fifo_full_i = 1'b0;
    cyc();
    chk("stall_left", sb.size(), 4);
    sample_vld_i = 1'b1; sample_otr_i = s[12]; sample_data_i = s[11:0]; cfg_stop_i = 1'b1;
    cyc();
    wait_idle();
    exp_fcnt = exp_fcnt + 8'd1;
    chk("frame_cnt_stall", frame_cnt_o, exp_fcnt);

    // overflow: three samples with FIFO full
    s = 13'h00F0;
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(exp_fcnt);
    push_smp(s); sb.push_back(8'hF0);
    fifo_full_i = 1'b1; cfg_arm_i = 1'b1;
    cyc();
    sample_vld_i = 1'b1; sample_otr_i = 1'b0; sample_data_i = s[11:0]; cyc();
    sample_vld_i = 1'b1; sample_data_i = 12'h111; cyc();
    sample_vld_i = 1'b1; sample_data_i = 12'h222; cyc();
    chk("ovf_cnt", ovf_cnt_o, 2); chk("ovf_flag", ovf_flag_o, 1);
    fifo_full_i = 1'b0; cfg_stop_i = 1'b1;
    cyc();
    wait_idle();
    exp_fcnt = exp_fcnt + 8'd1;
    chk("frame_cnt_ovf", frame_cnt_o, exp_fcnt);
    chk("ovf_hold_idle", ovf_cnt_o, 2);
    s = 13'h0321;
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(exp_fcnt);
    push_smp(s); sb.push_back(8'h22);
    cfg_arm_i = 1'b1;
    cyc();
    chk("ovf_clr_cnt", ovf_cnt_o, 0); chk("ovf_clr_flag", ovf_flag_o, 0);
    sample_vld_i = 1'b1; sample_otr_i = 1'b0; sample_data_i = s[11:0]; cfg_stop_i = 1'b1;
    cyc();
    wait_idle();
    exp_fcnt = exp_fcnt + 8'd1;
    chk("frame_cnt_arm2", frame_cnt_o, exp_fcnt);

    // reset while in SLO
    s = 13'h0789;
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(exp_fcnt);
    sb.push_back({s[12], 3'b000, s[11:8]});
    cfg_frame_len_i = 10'd2; cfg_arm_i = 1'b1;
    cyc();
    sample_vld_i = 1'b1; sample_otr_i = 1'b0; sample_data_i = s[11:0];
    repeat (4) cyc();
    chk("pre_rst_slo_wr", fifo_wr_o, 1);
    rst_i = 1'b1;
    #1;
    chk("arst_wr", fifo_wr_o, 0); chk("arst_data", fifo_data_o, 0); chk("arst_busy", busy_o, 0);
    chk("arst_fcnt", frame_cnt_o, 0); chk("arst_ovf", ovf_cnt_o, 0); chk("arst_flag", ovf_flag_o, 0);
    chk("arst_sb_left", sb.size(), 0);
    sb.delete();
    exp_fcnt = 8'h00;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc();
    for (int i = 0; i < vt[0].n; i++) smp_buf[i] = vt[0].smp[i];
    run_frame(vt[0].len, vt[0].n, vt[0].tail);

    // len = 0 means 1024 samples
    t = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      smp_buf[i] = {i[0], i[11:0] ^ 12'h5A5};
      t = t ^ {smp_buf[i][12], 3'b000, smp_buf[i][11:8]} ^ smp_buf[i][7:0];
    end
    run_frame(10'd0, 1024, t);

    // frame counter wrap FF -> 00
    smp_buf[0] = 13'h0042;
    while (exp_fcnt != 8'h00) run_frame(10'd1, 1, 8'h42);
    chk("fcnt_wrap", frame_cnt_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
